// File: rtl/ellipse_op_issuer.sv
// Host-programmed ellipse op queue: staging registers are committed into a FIFO
// and presented to the drawing engine with a registered ready-to-send handshake.
module ellipse_op_issuer #(
  parameter int DEPTH = 4,
  parameter int CW    = 10
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_addr,
  input  logic [11:0]                wr_data,
  output logic [4*CW+11:0]           out_op,
  output logic                       out_rts,
  input  logic                       out_rtr,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       cmd_full,
  output logic                       err_ovf,
  output logic                       err_zero,
  output logic                       dbg_state
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int OPW  = 4 * CW + 12;

  // Handshake: an op moves on a rising edge where out_rts=1 and out_rtr=1;
  // out_rts comes straight from a flop, and out_rtr is ignored while out_rts=0.
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     xc_q, xc_d, yc_q, yc_d, rx_q, rx_d, ry_q, ry_d;
  logic [11:0]       color_q, color_d;
  logic [OPW-1:0]    mem_q [DEPTH];
  logic [OPW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              err_ovf_q, err_ovf_d, err_zero_q, err_zero_d;

  logic              commit, rad_zero, full, push, pop;

  always_comb begin
    commit   = wr_en && (wr_addr == 3'd5);
    rad_zero = (rx_q == '0) || (ry_q == '0);
    full     = (count_q == CNTW'(DEPTH));
    push     = commit && !rad_zero && !full;
    pop      = (state_q == ST_PRESENT) && out_rtr;

    xc_d       = xc_q;
    yc_d       = yc_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    color_d    = color_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    err_ovf_d  = err_ovf_q | (commit && !rad_zero && full);
    err_zero_d = err_zero_q | (commit && rad_zero);

    if (wr_en) begin
      case (wr_addr)
        3'd0:    xc_d    = wr_data[CW-1:0];
        3'd1:    yc_d    = wr_data[CW-1:0];
        3'd2:    rx_d    = wr_data[CW-1:0];
        3'd3:    ry_d    = wr_data[CW-1:0];
        3'd4:    color_d = wr_data;
        default: ;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = {xc_q, yc_q, rx_q, ry_q, color_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      ST_EMPTY:   if (push) state_d = ST_PRESENT;
      ST_PRESENT: if (pop && (count_q == CNTW'(1)) && !push) state_d = ST_EMPTY;
      default:    state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q    <= ST_EMPTY;
      xc_q       <= '0;
      yc_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      color_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_zero_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      color_q    <= color_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_ovf_q  <= err_ovf_d;
      err_zero_q <= err_zero_d;
      mem_q      <= mem_d;
    end
  end

  // The head entry is only meaningful while presenting; drive zeros otherwise.
  assign out_op    = (state_q == ST_PRESENT) ? mem_q[rd_ptr_q] : '0;
  assign out_rts   = (state_q == ST_PRESENT);
  assign cmd_count = count_q;
  assign cmd_full  = (count_q == CNTW'(DEPTH));
  assign err_ovf   = err_ovf_q;
  assign err_zero  = err_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ellipse_op_issuer.sv
// Bench for ellipse_op_issuer: directed scenarios plus random traffic checked
// against a queue-based reference model with a scoreboard monitor.
module tb_ellipse_op_issuer;

  localparam int DEPTH = 4;
  localparam int CW    = 10;
  localparam int OPW   = 4 * CW + 12;

  logic              clk = 1'b0;
  logic              rst_;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [11:0]       wr_data;
  logic [OPW-1:0]    out_op;
  logic              out_rts;
  logic              out_rtr;
  logic [$clog2(DEPTH):0] cmd_count;
  logic              cmd_full;
  logic              err_ovf;
  logic              err_zero;
  logic              dbg_state;

  ellipse_op_issuer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_op(out_op), .out_rts(out_rts), .out_rtr(out_rtr), .cmd_count(cmd_count),
    .cmd_full(cmd_full), .err_ovf(err_ovf), .err_zero(err_zero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [OPW-1:0] exp_q[$];
  int             m_xc, m_yc, m_rx, m_ry, m_color;
  bit             m_ovf, m_zero, m_on, m_just_rst;
  int             n_checks = 0;
  int             n_fail   = 0;
  int             n_xfer   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model by the
  // effect of the inputs that will be sampled at the coming rising edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("out_rts",   64'(out_rts),   64'(exp_q.size() != 0));
      chk("cmd_count", 64'(cmd_count), 64'(exp_q.size()));
      chk("cmd_full",  64'(cmd_full),  64'(exp_q.size() == DEPTH));
      chk("err_ovf",   64'(err_ovf),   64'(m_ovf));
      chk("err_zero",  64'(err_zero),  64'(m_zero));
      if (exp_q.size() != 0) chk("out_op", 64'(out_op), 64'(exp_q[0]));
      else if (m_just_rst)   chk("out_op_reset", 64'(out_op), 64'd0);
    end
    m_just_rst = 1'b0;
    if (rst_) begin
      exp_q.delete();
      m_xc = 0; m_yc = 0; m_rx = 0; m_ry = 0; m_color = 0;
      m_ovf = 1'b0; m_zero = 1'b0;
      m_on = 1'b1; m_just_rst = 1'b1;
    end else if (m_on) begin
      bit was_full;
      was_full = (exp_q.size() == DEPTH);
      if (exp_q.size() != 0 && out_rtr) begin
        void'(exp_q.pop_front());
        n_xfer++;
      end
      if (wr_en) begin
        case (wr_addr)
          3'd0: m_xc = int'(wr_data) % (1 << CW);
          3'd1: m_yc = int'(wr_data) % (1 << CW);
          3'd2: m_rx = int'(wr_data) % (1 << CW);
          3'd3: m_ry = int'(wr_data) % (1 << CW);
          3'd4: m_color = int'(wr_data);
          3'd5: begin
            if (m_rx == 0 || m_ry == 0) m_zero = 1'b1;
            else if (was_full)          m_ovf = 1'b1;
            else exp_q.push_back(OPW'(m_xc) * (64'd1 << 42) + OPW'(m_yc) * (64'd1 << 32) +
                                 OPW'(m_rx) * (64'd1 << 22) + OPW'(m_ry) * (64'd1 << 12) +
                                 OPW'(m_color));
          end
          default: ;
        endcase
      end
    end
  end

  // Driver: one cycle of inputs, applied just after a rising edge.
  task automatic cyc(input bit en, input int addr, input int data, input bit rtr);
    @(posedge clk);
    #1;
    wr_en = en; wr_addr = 3'(addr); wr_data = 12'(data); out_rtr = rtr;
  endtask

  task automatic idle(input bit rtr);
    cyc(1'b0, 0, 0, rtr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_ = 1'b1; wr_en = 1'b0; out_rtr = 1'b0;
    idle(1'b0);
    @(posedge clk);
    #1;
    rst_ = 1'b0;
  endtask

  task automatic load_op(input int xc, input int yc, input int rx, input int ry,
                         input int col, input bit rtr);
    cyc(1'b1, 0, xc, rtr);
    cyc(1'b1, 1, yc, rtr);
    cyc(1'b1, 2, rx, rtr);
    cyc(1'b1, 3, ry, rtr);
    cyc(1'b1, 4, col, rtr);
  endtask

  initial begin
    rst_ = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_rtr = 1'b0;
    m_on = 1'b0; m_just_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;

    // Single op with known encoding
    load_op(2, 2, 2, 2, 12'hFFF, 1'b1);
    cyc(1'b1, 5, 0, 1'b1);
    idle(1'b1);
    chk("single_rts", 64'(out_rts), 64'd1);
    chk("single_op",  64'(out_op),  64'h0080200802FFF);
    idle(1'b1);
    chk("single_drained", 64'(cmd_count), 64'd0);

    // Backpressure with three distinct ops
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 0, 10 + i, 1'b0);
      cyc(1'b1, 5, 0, 1'b0);
    end
    repeat (10) idle(1'b0);
    chk("bp_count", 64'(cmd_count), 64'd3);
    repeat (4) idle(1'b1);

    // Overflow: five commits, then a full-FIFO commit coinciding with a pop
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1, 100 + i, 1'b0);
      cyc(1'b1, 5, 0, 1'b0);
    end
    idle(1'b0);
    chk("ovf_full", 64'(cmd_full), 64'd1);
    chk("ovf_flag", 64'(err_ovf),  64'd1);
    cyc(1'b1, 5, 0, 1'b1);
    repeat (6) idle(1'b1);
    do_reset();

    // Zero radius
    load_op(7, 8, 0, 5, 12'h123, 1'b0);
    cyc(1'b1, 5, 0, 1'b0);
    idle(1'b0);
    chk("zero_count", 64'(cmd_count), 64'd0);
    chk("zero_flag",  64'(err_zero),  64'd1);
    chk("zero_noovf", 64'(err_ovf),   64'd0);
    do_reset();

    // Steady push+pop at depth 2 across pointer wrap
    load_op(1, 1, 3, 3, 12'h0F0, 1'b0);
    cyc(1'b1, 5, 0, 1'b0);
    cyc(1'b1, 0, 2, 1'b0);
    cyc(1'b1, 5, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 0, 200 + i, 1'b0);
      cyc(1'b1, 5, 0, 1'b1);
    end
    idle(1'b0);
    chk("wrap_count", 64'(cmd_count), 64'd2);
    repeat (3) idle(1'b1);

    // Reset with ops queued and presented
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2, 30 + i, 1'b0);
      cyc(1'b1, 5, 0, 1'b0);
    end
    idle(1'b0);
    @(posedge clk);
    #1;
    rst_ = 1'b1; out_rtr = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    chk("rst_rts",   64'(out_rts),   64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    repeat (3) idle(1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      int a, d;
      a = $urandom_range(0, 7);
      d = (a == 2 || a == 3) ? $urandom_range(0, 4) : $urandom_range(0, 4095);
      if ($urandom_range(0, 2) == 0) a = 5;
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, a, d, $urandom_range(0, 2) != 0);
    end

    repeat (DEPTH + 3) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("saw_transfers", 64'(n_xfer > 20), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ellipse_op_issuer.md
ELLIPSE_OP_ISSUER -- requirements
Module: ellipse_op_issuer

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4, giving command FIFO depth in ops (power of 2, 2..16).
REQ-002 The block SHALL have parameter CW, default 10, giving coordinate/radius field width in bits.
Ports:
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_  in  1  reset, synchronous and active-high (rst_=1 resets on the next clk edge).
REQ-005 wr_en  in  1  host register write strobe, one write per cycle.
REQ-006 wr_addr  in  3  register select: 0=xc, 1=yc, 2=rx, 3=ry, 4=color, 5=commit, 6-7 ignored.
REQ-007 wr_data  in  12  write data; CW LSBs used for addr 0-3, all 12 bits for color, ignored for commit.
REQ-008 out_op  out  52  packed op: [51:42] xc, [41:32] yc, [31:22] rx, [21:12] ry, [11:0] color (R4G4B4).
REQ-009 out_rts  out  1  out_op valid toward the drawing engine.
REQ-010 out_rtr  in  1  drawing engine ready to accept an op.
REQ-011 cmd_count  out  $clog2(DEPTH)+1  ops held, including the one presented on out_op.
REQ-012 cmd_full  out  1  high when cmd_count == DEPTH.
REQ-013 err_ovf  out  1  sticky: a commit was dropped because the FIFO was full.
REQ-014 err_zero  out  1  sticky: a commit was rejected because rx or ry was 0.

Function
REQ-015 Staging registers xc, yc, rx, ry, color SHALL load wr_data on wr_en with matching wr_addr; they persist across commits, so repeated commits with no re-write re-issue the same op.
REQ-016 A write to addr 5 (commit) SHALL push {xc,yc,rx,ry,color} into the FIFO when not full and rx!=0 and ry!=0.
REQ-017 A commit while cmd_full=1 SHALL be dropped and set err_ovf, even if a transfer occurs in the same cycle.
REQ-018 A commit with rx==0 or ry==0 SHALL be dropped and set err_zero; this check takes priority, so err_ovf is not also set.
REQ-019 A transfer SHALL occur on a rising edge where out_rts=1 and out_rtr=1; that edge pops the head entry.
REQ-020 out_rts SHALL be registered and equal (cmd_count != 0); the FIFO has no combinational path from commit to out_rts or from out_rtr to out_rts.
REQ-021 Latency: a commit accepted into an empty FIFO at edge N SHALL give out_rts=1 with that op on out_op after edge N; the earliest transfer is edge N+1.
REQ-022 While out_rts=1 and out_rtr=0, out_op SHALL hold stable.
REQ-023 After a transfer with more entries pending, the next op SHALL appear on out_op immediately after that edge, so back-to-back transfers sustain 1 op/cycle.
REQ-024 Simultaneous accepted commit and transfer SHALL leave cmd_count unchanged; commit alone increments it; transfer alone decrements it.
REQ-025 Ops SHALL issue in strict commit order; read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 An output FSM SHALL have two states: EMPTY (out_rts=0) and PRESENT (out_rts=1).
REQ-027 FSM transitions: EMPTY->PRESENT on an accepted commit; PRESENT->EMPTY on a transfer with cmd_count==1 and no accepted commit in the same cycle; otherwise hold.
REQ-028 out_rtr SHALL be ignored while out_rts=0.
REQ-029 err_ovf and err_zero SHALL clear only on reset.

Reset
REQ-030 On a clk edge with rst_=1: FIFO emptied, pointers=0, cmd_count=0, cmd_full=0, out_rts=0, out_op=0, err_ovf=0, err_zero=0, staging registers=0, FSM=EMPTY.
REQ-031 Reset mid-operation SHALL discard all queued and presented ops; no transfer completes on the reset edge.
REQ-032 Host writes in the reset cycle SHALL be ignored.

Verification
REQ-033 Single op: write xc=2, yc=2, rx=2, ry=2, color=0xFFF, commit, out_rtr=1 -> out_rts=1 one cycle after commit, out_op=0x0080200802FFF, one transfer, then out_rts=0 and cmd_count=0.
REQ-034 Backpressure: queue 3 distinct ops with out_rtr=0 for 10 cycles -> out_op holds op0 and cmd_count=3; then raise out_rtr -> op0, op1, op2 transfer on 3 consecutive edges.
REQ-035 Overflow (DEPTH=4): 5 commits with out_rtr=0 -> cmd_full=1, cmd_count=4, err_ovf=1; after drain exactly 4 ops are observed; a 5th commit coinciding with a pop is also dropped.
REQ-036 Zero radius: rx=0, commit -> cmd_count stays 0, err_zero=1, err_ovf=0.
REQ-037 Simultaneous push/pop at cmd_count=2 -> cmd_count stays 2 and order is preserved across pointer wrap (issue 10 ops, observe all 10 in order).
REQ-038 Reset with 3 ops queued and out_rts=1 -> the next cycle shows out_rts=0, cmd_count=0, both error flags=0, and no further transfers.
